// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: shift mode encoding and FSM states.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_PASS = 3'b000,
        MODE_LSL  = 3'b001,
        MODE_LSR  = 3'b010,
        MODE_ASR  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Reserved codes 110/111 fall through to a pass-through like PASS.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= MODE_LSL) && (mode <= MODE_ROL);
    endfunction

endpackage

// File: rtl/shifter_step.sv
// One iteration of the shifter: moves data by k (0..STEP) bits and reports the last bit out.
module shifter_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  shift_mode_e      mode,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] next_data,
    output logic             carry
);

    logic [WIDTH:0]     lsl_ext;
    logic [WIDTH:0]     lsr_ext;
    logic [2*WIDTH-1:0] ror_ext;
    logic [2*WIDTH-1:0] rol_ext;

    // Guard bits beside the operand catch the last bit shifted out, which
    // chains correctly across steps so the final carry does not depend on STEP.
    always_comb begin
        lsl_ext   = {1'b0, data} << k;
        lsr_ext   = {data, 1'b0} >> k;
        ror_ext   = {data, data} >> k;
        rol_ext   = {data, data} << k;
        next_data = data;
        carry     = 1'b0;
        case (mode)
            MODE_LSL: begin
                next_data = data << k;
                carry     = lsl_ext[WIDTH];
            end
            MODE_LSR: begin
                next_data = data >> k;
                carry     = lsr_ext[0];
            end
            MODE_ASR: begin
                next_data = $unsigned($signed(data) >>> k);
                carry     = lsr_ext[0];
            end
            MODE_ROR: begin
                next_data = ror_ext[WIDTH-1:0];
                carry     = ror_ext[WIDTH-1];
            end
            MODE_ROL: begin
                next_data = rol_ext[2*WIDTH-1:WIDTH];
                carry     = rol_ext[WIDTH];
            end
            default: begin
                next_data = data;
                carry     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: accepts an operand, shifts it up to STEP bits per cycle,
// then holds the result until the consumer takes it.
//
//   state | meaning
//   IDLE  | ready for a request; in_ready=1
//   SHIFT | applying min(STEP,cnt) bits per cycle until cnt==0
//   DONE  | result presented; out_valid=1 until out_ready
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam int KW = $clog2(STEP + 1);

    state_e           state;
    shift_mode_e      mode_q;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] cnt_q;
    logic             carry_q;

    logic [AMT_W:0]   step_amt;
    logic [AMT_W-1:0] cnt_next;
    logic [KW-1:0]    step_k;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    // One extra bit so STEP==WIDTH still compares correctly against cnt.
    always_comb begin
        step_amt = {1'b0, cnt_q};
        if ({1'b0, cnt_q} > (AMT_W + 1)'(STEP)) begin
            step_amt = (AMT_W + 1)'(STEP);
        end
        cnt_next = cnt_q - step_amt[AMT_W-1:0];
        step_k   = KW'(step_amt);
    end

    shifter_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data      (data_q),
        .mode      (mode_q),
        .k         (step_k),
        .next_data (step_data),
        .carry     (step_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_PASS;
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        mode_q  <= shift_mode_e'(in_mode);
                        cnt_q   <= in_amt;
                        carry_q <= 1'b0;
                        if ((in_amt == '0) || !is_shift_mode(in_mode)) begin
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q  <= step_data;
                    carry_q <= step_carry;
                    cnt_q   <= cnt_next;
                    if (cnt_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (STEP=1 main instance, STEP=4 side instance).
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, out_valid, out_ready, out_carry, out_zero;
    logic [15:0] in_data, out_data;
    logic [2:0]  in_mode;
    logic [3:0]  in_amt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_carry, b_out_zero;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_in_mode;
    logic [3:0]  b_in_amt;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;
    bit   seen = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(16), .STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    iter_shifter #(.WIDTH(16), .STEP(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .in_amt    (b_in_amt),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_carry (b_out_carry),
        .out_zero  (b_out_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts cycles, timestamps accept and first out_valid, pops on output handshake.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                seen = 0;
            end else begin
                if (in_valid && in_ready) acc_cyc = cyc;
                if (out_valid && !seen) begin
                    seen = 1;
                    first_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    seen = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_data"}, 32'(out_data), 32'(e.data));
                        check({e.name, "_carry"}, 32'(out_carry), 32'(e.carry));
                        check({e.name, "_zero"}, 32'(out_zero), 32'(e.data == 16'h0000));
                        check({e.name, "_latency"}, 32'(first_cyc - acc_cyc), 32'(e.lat));
                    end
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic issue(input string name, input logic [15:0] d, input logic [2:0] m,
                         input logic [3:0] a, input logic [15:0] ed, input logic ec,
                         input int el, input bit push);
        bit rdy;
        int t = 0;
        in_data  = d;
        in_mode  = m;
        in_amt   = a;
        in_valid = 1'b1;
        if (push) sb.push_back('{ed, ec, el, name});
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 50);
        if (!rdy) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mode  = 3'($urandom);
        in_amt   = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [15:0] d, input logic [2:0] m,
                       input logic [3:0] a, input logic [15:0] ed, input logic ec, input int el);
        issue(name, d, m, a, ed, ec, el, 1'b1);
        drain();
    endtask

    task automatic b_run(input string name, input logic [15:0] d, input logic [2:0] m,
                         input logic [3:0] a, input logic [15:0] ed, input logic ec, input int el);
        int lat = 1;
        check({name, "_in_ready"}, 32'(b_in_ready), 32'd1);
        b_in_data  = d;
        b_in_mode  = m;
        b_in_amt   = a;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        while (!b_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(el));
        check({name, "_data"}, 32'(b_out_data), 32'(ed));
        check({name, "_carry"}, 32'(b_out_carry), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        in_valid = 1'b0; in_data = '0; in_mode = '0; in_amt = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_in_amt = '0; b_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_carry", 32'(out_carry), 32'd0);
        check("reset_out_zero", 32'(out_zero), 32'd1);
        check("reset_b_out_valid", 32'(b_out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   name          data      mode  amt  exp_data  carry lat
        run("lsl1",       16'hF0CF, 3'd1, 4'd1,  16'hE19E, 1'b1, 2);
        run("lsr4",       16'hF0CF, 3'd2, 4'd4,  16'h0F0C, 1'b1, 5);
        run("asr4",       16'hF0CF, 3'd3, 4'd4,  16'hFF0C, 1'b1, 5);
        run("ror8",       16'hF0CF, 3'd4, 4'd8,  16'hCFF0, 1'b1, 9);
        run("rol4",       16'hF0CF, 3'd5, 4'd4,  16'h0CFF, 1'b1, 5);
        run("lsl0",       16'hF0CF, 3'd1, 4'd0,  16'hF0CF, 1'b0, 1);
        run("rsvd7",      16'hF0CF, 3'd7, 4'd5,  16'hF0CF, 1'b0, 1);
        run("pass7",      16'hF0CF, 3'd0, 4'd7,  16'hF0CF, 1'b0, 1);
        run("lsr1_zero",  16'h0001, 3'd2, 4'd1,  16'h0000, 1'b1, 2);
        run("lsl4",       16'hF0CF, 3'd1, 4'd4,  16'h0CF0, 1'b1, 5);
        run("ror1",       16'hF0CF, 3'd4, 4'd1,  16'hF867, 1'b1, 2);
        run("lsr15",      16'hF0CF, 3'd2, 4'd15, 16'h0001, 1'b1, 16);
        run("asr15",      16'hF0CF, 3'd3, 4'd15, 16'hFFFF, 1'b1, 16);
        run("lsl15",      16'h0001, 3'd1, 4'd15, 16'h8000, 1'b0, 16);
        run("rol1",       16'h8000, 3'd5, 4'd1,  16'h0001, 1'b1, 2);
        run("asr4_pos",   16'h7000, 3'd3, 4'd4,  16'h0700, 1'b0, 5);

        // Back-pressure: result must hold while inputs churn.
        out_ready = 1'b0;
        issue("hold", 16'hF0CF, 3'd4, 4'd8, 16'hCFF0, 1'b1, 9, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("hold_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            in_mode  = 3'($urandom);
            in_amt   = 4'($urandom);
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", 32'(out_data), 32'hCFF0);
            check("hold_out_carry", 32'(out_carry), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset in the middle of a long shift discards it.
        issue("abort", 16'hF0CF, 3'd3, 4'd10, 16'h0000, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_out_zero", 32'(out_zero), 32'd1);
        run("after_rst", 16'hF0CF, 3'd3, 4'd4, 16'hFF0C, 1'b1, 5);

        // STEP=4 instance: same results, fewer cycles.
        b_run("s4_asr4",  16'hF0CF, 3'd3, 4'd4,  16'hFF0C, 1'b1, 2);
        b_run("s4_lsr15", 16'hF0CF, 3'd2, 4'd15, 16'h0001, 1'b1, 5);
        b_run("s4_rol4",  16'hF0CF, 3'd5, 4'd4,  16'h0CFF, 1'b1, 2);
        b_run("s4_lsl0",  16'hF0CF, 3'd1, 4'd0,  16'hF0CF, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
